// File: rtl/cosine_job_arbiter.sv
// Round-robin arbiter sharing one cosine_sim engine between N requesters.
// Optional watchdog enabled by defining COSINE_ARB_TIMEOUT_EN.
module cosine_job_arbiter #(
    parameter int N       = 4,
    parameter int W       = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N-1:0]                         req,
    input  logic [N*W*32-1:0]                    req_vec_a,
    input  logic [N*W*32-1:0]                    req_vec_b,
    output logic [N-1:0]                         done,
    output logic [31:0]                          rsp_similarity,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] rsp_id,
    output logic                                 rsp_timeout,
    output logic                                 busy,
    output logic                                 eng_start,
    output logic [W*32-1:0]                      eng_vec_a,
    output logic [W*32-1:0]                      eng_vec_b,
    input  logic [31:0]                          eng_similarity,
    input  logic                                 eng_valid,
    output logic                                 eng_flush,
    output logic [15:0]                          jobs_count
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int VW  = W * 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    if (N < 1 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("cosine_job_arbiter: unsupported parameter values");
    end

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [31:0]    sim_q, sim_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           to_q, to_d;
    logic [15:0]    jobs_q, jobs_d;
    logic           timeout_hit;

    // Lowest requesting index at or above p; falls back to lowest overall.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] pick;
        pick = p;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) pick = IDW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i] && i >= int'(p)) pick = IDW'(i);
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
        return (int'(g) == N - 1) ? '0 : g + 1'b1;
    endfunction

`ifdef COSINE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_q;

    // Counter holds completed WAIT cycles, so the limit is reached when it equals TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= (state_q == S_WAIT) ? wdog_q + 1'b1 : '0;
        end
    end

    assign timeout_hit = (wdog_q == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sim_d   = sim_q;
        rid_d   = rid_q;
        to_d    = to_q;
        jobs_d  = jobs_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, ptr_q);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A result arriving on the timeout cycle takes precedence.
                if (eng_valid) begin
                    sim_d   = eng_similarity;
                    rid_d   = grant_q;
                    to_d    = 1'b0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    sim_d   = QNAN;
                    rid_d   = grant_q;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                jobs_d  = jobs_q + 16'd1;
                ptr_d   = next_idx(grant_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sim_q   <= '0;
            rid_q   <= '0;
            to_q    <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sim_q   <= sim_d;
            rid_q   <= rid_d;
            to_q    <= to_d;
            jobs_q  <= jobs_d;
        end
    end

    always_comb begin
        eng_vec_a = '0;
        eng_vec_b = '0;
        done      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IDW'(i)) begin
                eng_vec_a = req_vec_a[i*VW +: VW];
                eng_vec_b = req_vec_b[i*VW +: VW];
                done[i]   = (state_q == S_DONE);
            end
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign eng_start      = (state_q == S_ISSUE);
    assign eng_flush      = (state_q == S_DONE) && to_q;
    assign rsp_similarity = sim_q;
    assign rsp_id         = rid_q;
    assign rsp_timeout    = to_q;
    assign jobs_count     = jobs_q;

endmodule

// File: tb/tb_cosine_job_arbiter.sv
// Directed bench for cosine_job_arbiter; the engine is emulated inline by each job.
module tb_cosine_job_arbiter;
    localparam int N  = 4;
    localparam int W  = 5;
    localparam int VW = W * 32;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;
`ifdef COSINE_ARB_TIMEOUT_EN
    localparam int L1 = 8;
`else
    localparam int L1 = 20;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*VW-1:0] req_vec_a, req_vec_b;
    logic [N-1:0]    done;
    logic [31:0]     rsp_similarity;
    logic [1:0]      rsp_id;
    logic            rsp_timeout, busy, eng_start, eng_flush;
    logic [VW-1:0]   eng_vec_a, eng_vec_b;
    logic [31:0]     eng_similarity;
    logic            eng_valid;
    logic [15:0]     jobs_count;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_jobs = '0;

    always #5 clk = ~clk;

    cosine_job_arbiter #(.N(N), .W(W), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
        .done(done), .rsp_similarity(rsp_similarity), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
        .busy(busy), .eng_start(eng_start), .eng_vec_a(eng_vec_a), .eng_vec_b(eng_vec_b),
        .eng_similarity(eng_similarity), .eng_valid(eng_valid), .eng_flush(eng_flush),
        .jobs_count(jobs_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vectors();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < W; j++) begin
                req_vec_a[(i*W+j)*32 +: 32] = 32'h3F80_0000 + 32'(i * 256 + j);
                req_vec_b[(i*W+j)*32 +: 32] = 32'h4000_0000 + 32'(i * 256 + j);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        eng_valid = 1'b0;
        exp_jobs = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called in an IDLE cycle with req already set; returns in the following IDLE cycle.
    task automatic do_job(input int id, input logic [31:0] res, input int k,
                          input logic use_valid, input logic exp_to, input logic drop);
        logic [N-1:0] exp_done;
        logic [31:0]  exp_sim;
        exp_done = N'(1) << id;
        exp_sim  = exp_to ? QNAN : res;
        tick();
        checks++; if (eng_start !== 1'b1 || busy !== 1'b1) $display("FAIL issue_start id%0d: start=%b busy=%b required 1 1", id, eng_start, busy); else passed++;
        checks++; if (eng_vec_a !== req_vec_a[id*VW +: VW]) $display("FAIL vec_a id%0d: got %h required %h", id, eng_vec_a, req_vec_a[id*VW +: VW]); else passed++;
        checks++; if (eng_vec_b !== req_vec_b[id*VW +: VW]) $display("FAIL vec_b id%0d: got %h required %h", id, eng_vec_b, req_vec_b[id*VW +: VW]); else passed++;
        tick();
        for (int c = 1; c < k; c++) begin
            checks++;
            if (done !== '0 || eng_start !== 1'b0 || busy !== 1'b1 || eng_flush !== 1'b0)
                $display("FAIL wait id%0d cyc%0d: done=%b start=%b busy=%b flush=%b required 0000 0 1 0", id, c, done, eng_start, busy, eng_flush);
            else passed++;
            tick();
        end
        eng_valid = use_valid;
        eng_similarity = res;
        tick();
        eng_valid = 1'b0;
        checks++; if (done !== exp_done) $display("FAIL done id%0d: got %b required %b", id, done, exp_done); else passed++;
        checks++; if (rsp_similarity !== exp_sim) $display("FAIL similarity id%0d: got %h required %h", id, rsp_similarity, exp_sim); else passed++;
        checks++; if (rsp_id !== 2'(id)) $display("FAIL rsp_id: got %0d required %0d", rsp_id, id); else passed++;
        checks++; if (rsp_timeout !== exp_to || eng_flush !== exp_to) $display("FAIL timeout_flags id%0d: to=%b flush=%b required %b", id, rsp_timeout, eng_flush, exp_to); else passed++;
        if (drop) req[id] = 1'b0;
        exp_jobs = exp_jobs + 16'd1;
        tick();
        checks++; if (busy !== 1'b0 || done !== '0 || eng_flush !== 1'b0) $display("FAIL idle id%0d: busy=%b done=%b flush=%b required 0 0000 0", id, busy, done, eng_flush); else passed++;
        checks++; if (jobs_count !== exp_jobs) $display("FAIL jobs_count: got %0d required %0d", jobs_count, exp_jobs); else passed++;
        checks++; if (rsp_similarity !== exp_sim || rsp_timeout !== exp_to) $display("FAIL rsp_hold id%0d: sim=%h to=%b required %h %b", id, rsp_similarity, rsp_timeout, exp_sim, exp_to); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        eng_valid = 1'b0;
        eng_similarity = '0;
        set_vectors();
        tick();
        checks++; if (done !== '0 || busy !== 1'b0 || eng_start !== 1'b0 || eng_flush !== 1'b0) $display("FAIL reset_ctrl: done=%b busy=%b start=%b flush=%b required all 0", done, busy, eng_start, eng_flush); else passed++;
        checks++; if (rsp_similarity !== '0 || rsp_id !== '0 || rsp_timeout !== 1'b0) $display("FAIL reset_rsp: sim=%h id=%0d to=%b required 0", rsp_similarity, rsp_id, rsp_timeout); else passed++;
        checks++; if (jobs_count !== '0) $display("FAIL reset_jobs: got %0d required 0", jobs_count); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== '0) $display("FAIL reset_idle: busy=%b done=%b required 0 0000", busy, done); else passed++;
    endtask

    task automatic test_single_job();
        for (int j = 0; j < W; j++) begin
            req_vec_a[j*32 +: 32] = ONE;
            req_vec_b[j*32 +: 32] = ONE;
        end
        req = 4'b0001;
        do_job(0, ONE, L1, 1'b1, 1'b0, 1'b1);
        checks++; if (eng_vec_a !== {W{ONE}}) $display("FAIL single_vec: got %h required all 1.0", eng_vec_a); else passed++;
    endtask

    task automatic test_round_robin();
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        set_vectors();
        req = 4'b1111;
        foreach (order[i]) do_job(order[i], 32'h3F00_0000 + 32'(i), 6, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_pointer_wrap();
        req_vec_a[2*VW +: VW] = {32'h0, 32'h0, 32'h0, 32'h0, ONE};
        req_vec_b[2*VW +: VW] = {32'h0, 32'h0, 32'h0, ONE, 32'h0};
        req = 4'b0110;
        do_job(1, 32'h3F33_3333, 4, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_orthogonal();
        do_job(2, 32'h0000_0000, 5, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_valid_outside_wait();
        req = '0;
        eng_similarity = 32'hDEAD_BEEF;
        eng_valid = 1'b1;
        tick();
        eng_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || done !== '0) $display("FAIL stray_valid_state: busy=%b done=%b required 0 0000", busy, done); else passed++;
        checks++; if (rsp_similarity !== 32'h0 || jobs_count !== exp_jobs) $display("FAIL stray_valid_rsp: sim=%h jobs=%0d required 0 %0d", rsp_similarity, jobs_count, exp_jobs); else passed++;
    endtask

    task automatic test_timeout();
`ifdef COSINE_ARB_TIMEOUT_EN
        req = 4'b0001;
        do_job(0, 32'h1234_5678, 10, 1'b0, 1'b1, 1'b1);
        req = 4'b0001;
        do_job(0, 32'h3F00_0000, 10, 1'b1, 1'b0, 1'b1);
`else
        req = 4'b0001;
        do_job(0, 32'h3E80_0000, 30, 1'b1, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_job();
        req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (done !== '0 || busy !== 1'b0 || eng_start !== 1'b0 || eng_flush !== 1'b0) $display("FAIL midrst_ctrl: done=%b busy=%b start=%b flush=%b required all 0", done, busy, eng_start, eng_flush); else passed++;
        checks++; if (rsp_similarity !== '0 || rsp_id !== '0 || rsp_timeout !== 1'b0 || jobs_count !== '0) $display("FAIL midrst_rsp: sim=%h id=%0d to=%b jobs=%0d required 0", rsp_similarity, rsp_id, rsp_timeout, jobs_count); else passed++;
        req = '0;
        exp_jobs = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (done !== '0 || busy !== 1'b0) $display("FAIL midrst_release: done=%b busy=%b required 0000 0", done, busy); else passed++;
        req = 4'b1000;
        do_job(3, 32'h3F40_0000, 4, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_pointer_wrap();
        test_orthogonal();
        test_valid_outside_wait();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
